// File: rtl/forward_sb.sv
// forward_sb: operand forwarding and load hazard unit for the decode/EX boundary.
//   Forwards the youngest in-flight write (EX, returning load, MEM, WB) to each
//   of NUM_RD read ports. It tracks one outstanding load in a scoreboard so that
//   load data may return after a variable latency.
//   Ports:
//     clk, rst (async, active-low)
//     rd_addr/rd_data   : packed read port addresses and register-file data
//     ex_*/mem_*/wb_*   : in-flight writers
//     ld_ret_valid/data : load return from data memory
//     f_rd_data         : forwarded operands
//     stall, ld_pend, hazard_timeout (sticky), stall_cnt (saturating)

// Per-port forwarding mux and hazard address match.
module forward_sb_lane #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int ZERO_REG = 0
) (
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rf_data,
  input  logic          ex_fwd,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_data,
  input  logic          ld_fwd,
  input  logic [AW-1:0] pend_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [DW-1:0] mem_wdata,
  input  logic          wb_we,
  input  logic [AW-1:0] wb_waddr,
  input  logic [DW-1:0] wb_wdata,
  output logic [DW-1:0] fwd_data,
  output logic          hit_ex,
  output logic          hit_pend
);
  logic zero;
  assign zero = (ZERO_REG != 0) && (addr == '0);

  always_comb begin
    hit_ex   = !zero && (addr == ex_waddr);
    hit_pend = !zero && (addr == pend_addr);
    fwd_data = rf_data;
    if (!zero) begin
      if (ex_fwd && hit_ex)                     fwd_data = ex_data;
      else if (ld_fwd && hit_pend)              fwd_data = ld_data;
      else if (mem_we && (mem_waddr == addr))   fwd_data = mem_wdata;
      else if (wb_we && (wb_waddr == addr))     fwd_data = wb_wdata;
    end
  end
endmodule

module forward_sb #(
  parameter int NUM_RD   = 3,
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int ZERO_REG = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  input  logic [NUM_RD*DW-1:0] rd_data,
  input  logic                 ex_reg_write,
  input  logic                 ex_dm_read,
  input  logic [1:0]           ex_sel,
  input  logic [AW-1:0]        ex_waddr,
  input  logic [DW-1:0]        ex_imm,
  input  logic [DW-1:0]        ex_alu,
  input  logic                 mem_reg_write,
  input  logic [AW-1:0]        mem_waddr,
  input  logic [DW-1:0]        mem_wdata,
  input  logic                 wb_reg_write,
  input  logic [AW-1:0]        wb_waddr,
  input  logic [DW-1:0]        wb_wdata,
  input  logic                 ld_ret_valid,
  input  logic [DW-1:0]        ld_ret_data,
  output logic [NUM_RD*DW-1:0] f_rd_data,
  output logic                 stall,
  output logic                 ld_pend,
  output logic                 hazard_timeout,
  output logic [15:0]          stall_cnt
);
  localparam int RW = $clog2(TIMEOUT) + 1;

  logic [NUM_RD-1:0][AW-1:0] addr_a;
  logic [NUM_RD-1:0][DW-1:0] rdat_a, fwd_a;
  logic [NUM_RD-1:0]         hit_ex, hit_pend;

  logic          ld_pend_q, ld_pend_d;
  logic [AW-1:0] pend_addr_q, pend_addr_d;
  logic [RW-1:0] run_q, run_d;
  logic          hazard_timeout_q, hazard_timeout_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic          ex_fwd, ld_fwd;
  logic [DW-1:0] ex_data;
  logic          stall_a, stall_b, stall_c, issue;

  assign addr_a    = rd_addr;
  assign rdat_a    = rd_data;
  assign f_rd_data = fwd_a;

  // Loads never forward from EX; ex_sel 2/3 have no value yet.
  assign ex_fwd  = ex_reg_write && !ex_dm_read && !ex_sel[1];
  assign ex_data = ex_sel[0] ? ex_alu : ex_imm;
  assign ld_fwd  = ld_pend_q && ld_ret_valid;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_lane
    forward_sb_lane #(.AW(AW), .DW(DW), .ZERO_REG(ZERO_REG)) u_lane (
      .addr      (addr_a[i]),
      .rf_data   (rdat_a[i]),
      .ex_fwd    (ex_fwd),
      .ex_waddr  (ex_waddr),
      .ex_data   (ex_data),
      .ld_fwd    (ld_fwd),
      .pend_addr (pend_addr_q),
      .ld_data   (ld_ret_data),
      .mem_we    (mem_reg_write),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata),
      .wb_we     (wb_reg_write),
      .wb_waddr  (wb_waddr),
      .wb_wdata  (wb_wdata),
      .fwd_data  (fwd_a[i]),
      .hit_ex    (hit_ex[i]),
      .hit_pend  (hit_pend[i])
    );
  end

  always_comb begin
    stall_a = ex_dm_read && ex_reg_write && (|hit_ex);
    stall_b = ld_pend_q && !ld_ret_valid && (|hit_pend);
    // Only one load can be outstanding; a new one waits unless the slot frees now.
    stall_c = ex_dm_read && ld_pend_q && !ld_ret_valid;
    stall   = stall_a || stall_b || stall_c;
    issue   = ex_dm_read && ex_reg_write && !stall_c;

    ld_pend_d   = ld_pend_q;
    pend_addr_d = pend_addr_q;
    if (issue) begin
      ld_pend_d   = 1'b1;
      pend_addr_d = ex_waddr;
    end else if (ld_fwd) begin
      ld_pend_d   = 1'b0;
    end

    run_d = '0;
    if (stall) run_d = (run_q == RW'(TIMEOUT)) ? run_q : run_q + 1'b1;

    hazard_timeout_d = hazard_timeout_q || (stall && (run_q >= RW'(TIMEOUT - 1)));

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_pend_q        <= 1'b0;
      pend_addr_q      <= '0;
      run_q            <= '0;
      hazard_timeout_q <= 1'b0;
      stall_cnt_q      <= '0;
    end else begin
      ld_pend_q        <= ld_pend_d;
      pend_addr_q      <= pend_addr_d;
      run_q            <= run_d;
      hazard_timeout_q <= hazard_timeout_d;
      stall_cnt_q      <= stall_cnt_d;
    end
  end

  assign ld_pend        = ld_pend_q;
  assign hazard_timeout = hazard_timeout_q;
  assign stall_cnt      = stall_cnt_q;
endmodule

// File: tb/tb_forward_sb.sv
module tb_forward_sb;
  localparam int NUM_RD = 3, AW = 5, DW = 32;

  logic                 clk, rst;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic                 ex_reg_write, ex_dm_read;
  logic [1:0]           ex_sel;
  logic [AW-1:0]        ex_waddr, mem_waddr, wb_waddr;
  logic [DW-1:0]        ex_imm, ex_alu, mem_wdata, wb_wdata, ld_ret_data;
  logic                 mem_reg_write, wb_reg_write, ld_ret_valid;

  logic [NUM_RD*DW-1:0] f_rd_data, f_rd_data0;
  logic                 stall, ld_pend, hazard_timeout;
  logic                 stall0, ld_pend0, hazard_timeout0;
  logic [15:0]          stall_cnt, stall_cnt0;

  int vectors = 0;
  int miscompares = 0;

  // Main DUT masks r0; the second instance forwards r0 like any register.
  forward_sb #(.NUM_RD(NUM_RD), .AW(AW), .DW(DW), .ZERO_REG(1), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .ex_reg_write(ex_reg_write), .ex_dm_read(ex_dm_read), .ex_sel(ex_sel),
    .ex_waddr(ex_waddr), .ex_imm(ex_imm), .ex_alu(ex_alu),
    .mem_reg_write(mem_reg_write), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ld_ret_valid(ld_ret_valid), .ld_ret_data(ld_ret_data),
    .f_rd_data(f_rd_data), .stall(stall), .ld_pend(ld_pend),
    .hazard_timeout(hazard_timeout), .stall_cnt(stall_cnt));

  forward_sb #(.NUM_RD(NUM_RD), .AW(AW), .DW(DW), .ZERO_REG(0), .TIMEOUT(8)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .ex_reg_write(ex_reg_write), .ex_dm_read(ex_dm_read), .ex_sel(ex_sel),
    .ex_waddr(ex_waddr), .ex_imm(ex_imm), .ex_alu(ex_alu),
    .mem_reg_write(mem_reg_write), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .wb_reg_write(wb_reg_write), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .ld_ret_valid(ld_ret_valid), .ld_ret_data(ld_ret_data),
    .f_rd_data(f_rd_data0), .stall(stall0), .ld_pend(ld_pend0),
    .hazard_timeout(hazard_timeout0), .stall_cnt(stall_cnt0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic idle();
    ex_reg_write = 0; ex_dm_read = 0; ex_sel = 0; ex_waddr = 0; ex_imm = 0; ex_alu = 0;
    mem_reg_write = 0; mem_waddr = 0; mem_wdata = 0;
    wb_reg_write = 0; wb_waddr = 0; wb_wdata = 0;
    ld_ret_valid = 0; ld_ret_data = 0;
    set_addr(5'd1, 5'd2, 5'd3);
  endtask

  task automatic load(input logic [AW-1:0] a);
    ex_reg_write = 1; ex_dm_read = 1; ex_sel = 2'd2; ex_waddr = a;
  endtask

  initial begin
    rd_data = {32'h1002, 32'h1001, 32'h1000};
    idle();
    rst = 0;
    #2;
    chk("rst_ld_pend", ld_pend, 0);
    chk("rst_timeout", hazard_timeout, 0);
    chk("rst_cnt", stall_cnt, 0);
    chk("rst_stall", stall, 0);
    chk("rst_port0", f_rd_data[31:0], 32'h1000);
    tick();
    rst = 1;
    tick();

    // ALU forwarding beats MEM
    ex_reg_write = 1; ex_sel = 2'd1; ex_waddr = 5'd3; ex_alu = 32'h1234; ex_imm = 32'h7777;
    mem_reg_write = 1; mem_waddr = 5'd3; mem_wdata = 32'h5555;
    set_addr(5'd1, 5'd3, 5'd4);
    #1;
    chk("alu_port1", f_rd_data[63:32], 32'h1234);
    chk("alu_stall", stall, 0);
    chk("alu_port0", f_rd_data[31:0], 32'h1000);
    chk("alu_port2", f_rd_data[95:64], 32'h1002);
    ex_sel = 2'd0; #1;
    chk("imm_port1", f_rd_data[63:32], 32'h7777);
    ex_sel = 2'd2; #1;
    chk("sel2_port1", f_rd_data[63:32], 32'h5555);
    ex_sel = 2'd1; ex_dm_read = 1; #1;
    chk("ldex_port1", f_rd_data[63:32], 32'h5555);
    chk("ldex_stall", stall, 1);
    idle();

    // Priority chain MEM > WB > register file
    mem_reg_write = 1; mem_waddr = 5'd7; mem_wdata = 32'hAA;
    wb_reg_write = 1; wb_waddr = 5'd7; wb_wdata = 32'hBB;
    set_addr(5'd7, 5'd2, 5'd3);
    #1;
    chk("prio_mem", f_rd_data[31:0], 32'hAA);
    mem_reg_write = 0; #1;
    chk("prio_wb", f_rd_data[31:0], 32'hBB);
    wb_reg_write = 0; #1;
    chk("prio_rf", f_rd_data[31:0], 32'h1000);
    tick();

    // Load-use with 3-cycle return
    idle(); load(5'd5); set_addr(5'd1, 5'd2, 5'd5); #1;
    chk("lu_c0_stall", stall, 1);
    chk("lu_c0_pend", ld_pend, 0);
    tick();
    ex_reg_write = 0; ex_dm_read = 0; #1;
    chk("lu_c1_pend", ld_pend, 1);
    chk("lu_c1_stall", stall, 1);
    tick();
    chk("lu_c2_stall", stall, 1);
    tick();
    ld_ret_valid = 1; ld_ret_data = 32'hDEAD; #1;
    chk("lu_ret_port2", f_rd_data[95:64], 32'hDEAD);
    chk("lu_ret_stall", stall, 0);
    chk("lu_ret_cnt", stall_cnt, 3);
    tick();
    ld_ret_valid = 0; #1;
    chk("lu_after_pend", ld_pend, 0);
    chk("lu_after_port2", f_rd_data[95:64], 32'h1002);
    chk("lu_after_cnt", stall_cnt, 3);

    // Structural hazard: second load waits for the first to return
    idle(); load(5'd5); #1;
    chk("st_issue_stall", stall, 0);
    tick();
    load(5'd9); #1;
    chk("st_c_stall", stall, 1);
    tick();
    chk("st_c_stall2", stall, 1);
    chk("st_c_pend", ld_pend, 1);
    tick();
    ld_ret_valid = 1; ld_ret_data = 32'hBEEF; #1;
    chk("st_ret_stall", stall, 0);
    tick();
    idle(); set_addr(5'd9, 5'd2, 5'd3); #1;
    chk("st_new_pend", ld_pend, 1);
    chk("st_new_addr_hit", stall, 1);
    set_addr(5'd5, 5'd2, 5'd3); #1;
    chk("st_old_addr_free", stall, 0);
    set_addr(5'd9, 5'd2, 5'd3); ld_ret_valid = 1; ld_ret_data = 32'h1111; #1;
    chk("st_ret2_port0", f_rd_data[31:0], 32'h1111);
    chk("st_ret2_stall", stall, 0);
    tick();
    idle(); #1;
    chk("st_done_pend", ld_pend, 0);
    chk("st_cnt", stall_cnt, 5);

    // Watchdog: load to r6 never returns, reader waits
    load(5'd6); #1;
    chk("wd_issue_stall", stall, 0);
    tick();
    idle(); set_addr(5'd6, 5'd2, 5'd3);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("wd_stall_%0d", i), stall, 1);
      chk($sformatf("wd_pre_to_%0d", i), hazard_timeout, 0);
      tick();
    end
    chk("wd_timeout", hazard_timeout, 1);
    set_addr(5'd1, 5'd2, 5'd3);
    tick();
    chk("wd_sticky", hazard_timeout, 1);
    chk("wd_nostall", stall, 0);
    chk("wd_cnt", stall_cnt, 13);
    chk("wd_pend", ld_pend, 1);

    // Asynchronous reset drops the outstanding load
    rst = 0; #1;
    chk("ar_pend", ld_pend, 0);
    chk("ar_timeout", hazard_timeout, 0);
    chk("ar_cnt", stall_cnt, 0);
    rst = 1;
    tick();
    set_addr(5'd6, 5'd2, 5'd3); ld_ret_valid = 1; ld_ret_data = 32'h2222; #1;
    chk("late_ret_port0", f_rd_data[31:0], 32'h1000);
    chk("late_ret_stall", stall, 0);
    tick();
    idle(); #1;
    chk("late_ret_pend", ld_pend, 0);

    // ZERO_REG: r0 never forwarded and never stalls
    load(5'd0); set_addr(5'd0, 5'd2, 5'd3); #1;
    chk("z_lu_stall", stall, 0);
    chk("z0_lu_stall", stall0, 1);
    tick();
    ex_reg_write = 0; ex_dm_read = 0; #1;
    chk("z_pend_stall", stall, 0);
    chk("z0_pend_stall", stall0, 1);
    ld_ret_valid = 1; ld_ret_data = 32'h3333; #1;
    chk("z_ret_port0", f_rd_data[31:0], 32'h1000);
    chk("z0_ret_port0", f_rd_data0[31:0], 32'h3333);
    tick();
    idle(); set_addr(5'd0, 5'd2, 5'd3);
    ex_reg_write = 1; ex_sel = 2'd1; ex_waddr = 5'd0; ex_alu = 32'h4444; #1;
    chk("z_alu_port0", f_rd_data[31:0], 32'h1000);
    chk("z0_alu_port0", f_rd_data0[31:0], 32'h4444);
    tick();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/forward_sb.md
# forward_sb

Parametrised operand-forwarding and hazard unit for the decode/EX boundary of the TiniSOC pipeline. It supports N read ports instead of the fixed ra/rb/rt trio. Its main addition is a one-entry load scoreboard, so data memory may return load data after a variable number of cycles. It forwards the youngest in-flight write to every read port, stalls on load-use and structural load hazards, counts stall cycles, and flags a watchdog timeout when a load never returns.

## Interface
Parameters:
- NUM_RD, 3: number of read ports.
- AW, 5: register address width.
- DW, 32: data width.
- ZERO_REG, 0: when 1, address 0 is never forwarded and never causes a hazard.
- TIMEOUT, 64: consecutive stall cycles before hazard_timeout asserts (≥2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- rd_addr  in  NUM_RD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  in  NUM_RD*DW  register-file read data, packed the same way
- ex_reg_write  in  1  EX instruction writes a register
- ex_dm_read  in  1  EX instruction is a load
- ex_sel  in  2  EX write source: 0 = immediate, 1 = ALU result; 2 and 3 are not forwardable
- ex_waddr  in  AW  EX destination
- ex_imm  in  DW  EX extended immediate
- ex_alu  in  DW  EX ALU result
- mem_reg_write  in  1  MEM-stage non-load write (loads excluded by the caller)
- mem_waddr  in  AW  MEM destination
- mem_wdata  in  DW  MEM write data
- wb_reg_write  in  1  WB-stage write
- wb_waddr  in  AW  WB destination
- wb_wdata  in  DW  WB write data
- ld_ret_valid  in  1  load data returning this cycle
- ld_ret_data  in  DW  returned load data
- f_rd_data  out  NUM_RD*DW  forwarded operands
- stall  out  1  hold IF/ID, inject bubble into EX
- ld_pend  out  1  a load is outstanding
- hazard_timeout  out  1  sticky watchdog flag
- stall_cnt  out  16  saturating count of stall cycles

## Operation
**Per-port forwarding** is combinational. The first matching source in this order wins:
1. EX stage: ex_reg_write && !ex_dm_read && ex_sel∈{0,1} && ex_waddr==addr. Data is ex_imm when ex_sel=0, ex_alu when ex_sel=1.
2. Load return: ld_pend && ld_ret_valid && pend_addr==addr. Data is ld_ret_data.
3. MEM stage: mem_reg_write && mem_waddr==addr. Data is mem_wdata.
4. WB stage: wb_reg_write && wb_waddr==addr. Data is wb_wdata.
5. Otherwise the port passes rd_data.

When ZERO_REG=1 and addr==0, the port always passes rd_data.

**Scoreboard state:** ld_pend, pend_addr[AW], run[log2(TIMEOUT)+1].

**Stall**, combinational. stall = A || B || C, where:
- A, load-use: ex_dm_read && ex_reg_write && some port's addr==ex_waddr.
- B, pending-use: ld_pend && !ld_ret_valid && some port's addr==pend_addr.
- C, structural: ex_dm_read && ld_pend && !ld_ret_valid.
- ZERO_REG applies to the address matches in A and B.

**Scoreboard update**, clocked. Let issue = ex_dm_read && ex_reg_write && !C. Then:
- issue: ld_pend←1 and pend_addr←ex_waddr. This takes priority over a simultaneous return.
- else ld_pend && ld_ret_valid: ld_pend←0.
- ld_ret_valid while !ld_pend is ignored.

**Watchdog:**
- While stall is high, run increments, saturating at TIMEOUT. It clears when stall is low.
- When run reaches TIMEOUT-1 and stall is still high, hazard_timeout←1. It stays at 1 until reset.

**Counter:** stall_cnt increments on every cycle stall is high and saturates at 16'hFFFF.

## Timing
- Reset (rst=0, asynchronous) sets ld_pend=0, pend_addr=0, run=0, hazard_timeout=0, stall_cnt=0.
- f_rd_data and stall are combinational and follow the inputs with zero latency.
- A load that issues at edge t shows ld_pend=1 from cycle t+1. On a return at cycle k, the data is forwarded in cycle k and ld_pend=0 from k+1.
- Back-to-back loads: a second load in EX in the same cycle as a return does not stall. It re-arms the scoreboard with its own address.
- Reset during an outstanding load drops the entry. A late ld_ret_valid after that is ignored.
- Minimum load-use penalty is 1 stall cycle (term A), plus one cycle per cycle of return latency beyond that (term B).

## Test plan
- ALU forwarding: EX writes r3 with ex_alu=0x1234 while MEM writes r3=0x5555 and port 1 reads r3. Required: port 1 = 0x1234, stall=0.
- Priority chain: MEM r7=0xAA, WB r7=0xBB, port 0 reads r7. Required: port 0 = 0xAA. Drop mem_reg_write and port 0 becomes 0xBB.
- Load-use with 3-cycle return: a load to r5 followed by a reader of r5. Required: stall high for 3 cycles. In the return cycle port = ld_ret_data=0xDEAD and stall=0; the next cycle ld_pend=0; stall_cnt=3.
- Structural hazard: a second load in EX while the first is pending with no return. Required: stall=1 and pend_addr unchanged. On the return cycle stall=0 and pend_addr←new waddr.
- Watchdog: TIMEOUT=8, pending load never returns, a reader waits. Required: hazard_timeout=1 after the 8th stall cycle. It stays 1 after the stall clears and drops only on rst=0.
- ZERO_REG=1: load to r0 followed by a reader of r0. Required: stall=0 and port = rd_data.
